// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding,
// register-index width and the default multi-cycle EX latency.
package pipe_hazard_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MC_BUSY = 1'b1
   } hz_state_e;

   localparam int REG_IDX_W  = 5;
   localparam int DEF_MC_LAT = 32;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Pair of wrapping performance counters (stall cycles, flush cycles).
module hazard_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_inc,
   input  logic             flush_inc,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_inc ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = flush_inc ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX
// redirects, multi-cycle EX ops and data-memory wait states.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MC_LAT = DEF_MC_LAT,
   parameter int CNT_W  = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_RegWrite,
   input  logic                 ex_ltype,
   input  logic                 ex_redirect,
   input  logic                 ex_mc_start,
   input  logic                 mem_wait,
   output logic                 pc_stall,
   output logic                 ifid_pause,
   output logic                 ifid_flush,
   output logic                 idex_pause,
   output logic                 idex_flush,
   output logic                 idex_hold,
   output logic                 exmem_pause,
   output logic                 exmem_hold,
   output logic                 memwb_pause,
   output logic                 mc_busy,
   output logic                 mc_done,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   localparam int              MC_W    = $clog2(MC_LAT);
   localparam logic [MC_W-1:0] MC_INIT = MC_W'(MC_LAT - 2);

   hz_state_e       state_q, state_d;
   logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
   logic            mc_done_q, mc_done_d;
   logic            load_use;

   assign load_use = ex_ltype & ex_RegWrite & (ex_rd != '0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));

   always_comb begin
      state_d     = state_q;
      mc_cnt_d    = mc_cnt_q;
      mc_done_d   = 1'b0;
      pc_stall    = 1'b0;
      ifid_pause  = 1'b0;
      ifid_flush  = 1'b0;
      idex_pause  = 1'b0;
      idex_flush  = 1'b0;
      idex_hold   = 1'b0;
      exmem_pause = 1'b0;
      exmem_hold  = 1'b0;
      memwb_pause = 1'b0;
      mc_busy     = 1'b0;
      if (!resetn) begin
         if (mem_wait) begin
            // Whole pipe frozen; EX re-presents redirect/mc_start next cycle.
            pc_stall    = 1'b1;
            ifid_pause  = 1'b1;
            idex_hold   = 1'b1;
            exmem_hold  = 1'b1;
            memwb_pause = 1'b1;
            mc_busy     = (state_q == MC_BUSY);
         end else if (state_q == MC_BUSY) begin
            pc_stall    = 1'b1;
            ifid_pause  = 1'b1;
            idex_hold   = 1'b1;
            exmem_pause = 1'b1;
            mc_busy     = 1'b1;
            if (mc_cnt_q == '0) begin
               state_d   = RUN;
               mc_done_d = 1'b1;
            end else begin
               mc_cnt_d = mc_cnt_q - 1'b1;
            end
         end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (ex_mc_start) begin
            // Start cycle counts toward occupancy, so MC_BUSY lasts MC_LAT-1.
            pc_stall    = 1'b1;
            ifid_pause  = 1'b1;
            idex_hold   = 1'b1;
            exmem_pause = 1'b1;
            mc_busy     = 1'b1;
            state_d     = MC_BUSY;
            mc_cnt_d    = MC_INIT;
         end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_pause = 1'b1;
            idex_pause = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q   <= RUN;
         mc_cnt_q  <= '0;
         mc_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mc_cnt_q  <= mc_cnt_d;
         mc_done_q <= mc_done_d;
      end
   end

   assign mc_done = mc_done_q;

   hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
      .clk       (clk),
      .rst       (resetn),
      .stall_inc (pc_stall),
      .flush_inc (idex_flush),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed
// by random traffic, checked against a remaining-cycles reference model.
module tb_pipe_hazard_ctrl;

   localparam int MC_LAT = 32;
   localparam int CNT_W  = 32;

   typedef struct {
      logic [9:0]       outs;
      logic             done;
      logic [CNT_W-1:0] scnt;
      logic [CNT_W-1:0] fcnt;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_use_rs1, id_use_rs2, ex_RegWrite, ex_ltype, ex_redirect, ex_mc_start, mem_wait;
   logic pc_stall, ifid_pause, ifid_flush, idex_pause, idex_flush, idex_hold;
   logic exmem_pause, exmem_hold, memwb_pause, mc_busy, mc_done;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference model state
   int               busy_left = 0;
   logic             m_done    = 1'b0;
   logic [CNT_W-1:0] m_scnt    = '0;
   logic [CNT_W-1:0] m_fcnt    = '0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_ltype(ex_ltype),
      .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start), .mem_wait(mem_wait),
      .pc_stall(pc_stall), .ifid_pause(ifid_pause), .ifid_flush(ifid_flush),
      .idex_pause(idex_pause), .idex_flush(idex_flush), .idex_hold(idex_hold),
      .exmem_pause(exmem_pause), .exmem_hold(exmem_hold), .memwb_pause(memwb_pause),
      .mc_busy(mc_busy), .mc_done(mc_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Drive one cycle of inputs and push the model's expectation for it.
   task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic lt, input logic redir,
                       input logic start, input logic wt);
      exp_t e;
      logic lu, busy;
      logic ps, ip, ifl, dp, dfl, dh, ep, eh, wp, mb;
      @(posedge clk);
      #1;
      resetn = rst; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      ex_rd = rd; ex_RegWrite = rw; ex_ltype = lt; ex_redirect = redir;
      ex_mc_start = start; mem_wait = wt;

      lu = lt && rw && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      busy = busy_left > 0;
      {ps, ip, ifl, dp, dfl, dh, ep, eh, wp, mb} = '0;
      if (rst) begin
      end else if (wt) begin
         ps = 1; ip = 1; dh = 1; eh = 1; wp = 1; mb = busy;
      end else if (busy || (!redir && start)) begin
         ps = 1; ip = 1; dh = 1; ep = 1; mb = 1;
      end else if (redir) begin
         ifl = 1; dfl = 1;
      end else if (lu) begin
         ps = 1; ip = 1; dp = 1;
      end
      e.outs = {ps, ip, ifl, dp, dfl, dh, ep, eh, wp, mb};
      e.done = m_done;
      e.scnt = m_scnt;
      e.fcnt = m_fcnt;
      exp_q.push_back(e);

      // advance the model across the coming clock edge
      if (rst) begin
         busy_left = 0; m_done = 0; m_scnt = '0; m_fcnt = '0;
      end else begin
         m_done = !wt && busy_left == 1;
         if (!wt) begin
            if (busy) busy_left = busy_left - 1;
            else if (!redir && start) busy_left = MC_LAT - 1;
         end
         m_scnt = m_scnt + CNT_W'(ps);
         m_fcnt = m_fcnt + CNT_W'(dfl);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every cycle the DUT presents a full output set; pop and compare.
   initial begin
      exp_t e;
      logic [9:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {pc_stall, ifid_pause, ifid_flush, idex_pause, idex_flush,
                   idex_hold, exmem_pause, exmem_hold, memwb_pause, mc_busy};
            n_checks += 4;
            if (act !== e.outs) begin
               n_fail++;
               $display("FAIL outs t=%0t got %b want %b", $time, act, e.outs);
            end
            if (mc_done !== e.done) begin
               n_fail++;
               $display("FAIL mc_done t=%0t got %b want %b", $time, mc_done, e.done);
            end
            if (stall_cnt !== e.scnt) begin
               n_fail++;
               $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, stall_cnt, e.scnt);
            end
            if (flush_cnt !== e.fcnt) begin
               n_fail++;
               $display("FAIL flush_cnt t=%0t got %0d want %0d", $time, flush_cnt, e.fcnt);
            end
         end
      end
   end

   initial begin
      resetn = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_rd = 0; ex_RegWrite = 0; ex_ltype = 0; ex_redirect = 0; ex_mc_start = 0; mem_wait = 0;
      // reset, with hazard inputs active to prove outputs are forced low
      step(1, 5, 0, 1, 0, 5, 1, 1, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // load-use on x5, then the bubble cycle
      step(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
      idle(2);
      // load to x0 read by ID: no stall
      step(0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
      idle(1);
      // redirect concurrent with load-use
      step(0, 7, 7, 1, 1, 7, 1, 1, 1, 0, 0);
      idle(2);
      // multi-cycle op, undisturbed
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(MC_LAT + 2);
      // multi-cycle op with 3 wait cycles mid-flight
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(5);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(MC_LAT);
      // reset during MC_BUSY
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(9);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(199) == 0,
              5'($urandom_range(3)), 5'($urandom_range(3)),
              1'($urandom), 1'($urandom), 5'($urandom_range(3)),
              1'($urandom), 1'($urandom),
              $urandom_range(9) == 0, $urandom_range(29) == 0,
              $urandom_range(7) == 0);
      end
      idle(2);
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
